// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with registered single-cycle ops and an iterative
// multiply/divide unit (HI/LO) behind a valid/ready input handshake.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready request handshake;
//   control (op code), read1 (A), foutput (B); out_valid pulse with out,
//   zero (branch compare), overflow (signed add/sub), div_by_zero; busy.
module alu_mdu #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] control,
    input  logic [WIDTH-1:0]  read1,
    input  logic [WIDTH-1:0]  foutput,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out,
    output logic              zero,
    output logic              overflow,
    output logic              div_by_zero,
    output logic              busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    localparam logic [CTRL_W-1:0] F_AND0  = CTRL_W'(36);
    localparam logic [CTRL_W-1:0] F_AND1  = CTRL_W'(12);
    localparam logic [CTRL_W-1:0] F_OR0   = CTRL_W'(35);
    localparam logic [CTRL_W-1:0] F_OR1   = CTRL_W'(13);
    localparam logic [CTRL_W-1:0] F_NOR   = CTRL_W'(39);
    localparam logic [CTRL_W-1:0] F_ADD   = CTRL_W'(16);
    localparam logic [CTRL_W-1:0] F_ADDU  = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] F_SUB   = CTRL_W'(34);
    localparam logic [CTRL_W-1:0] F_SLT0  = CTRL_W'(42);
    localparam logic [CTRL_W-1:0] F_SLT1  = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] F_SLTU  = CTRL_W'(43);
    localparam logic [CTRL_W-1:0] F_BEQ   = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] F_BNE   = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] F_MFLO  = CTRL_W'(18);
    localparam logic [CTRL_W-1:0] F_MFHI  = CTRL_W'(17);
    localparam logic [CTRL_W-1:0] F_MULT  = CTRL_W'(24);
    localparam logic [CTRL_W-1:0] F_MULTU = CTRL_W'(25);
    localparam logic [CTRL_W-1:0] F_DIV   = CTRL_W'(26);
    localparam logic [CTRL_W-1:0] F_DIVU  = CTRL_W'(27);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  bmag_q, bmag_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              div_op_q, div_op_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              dbz_q, dbz_d;
    logic              out_valid_q, out_valid_d;

    logic              accept;
    logic              is_mul, is_div, is_mdu, is_signed;
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH-1:0]  sum_w, diff_w;
    logic              add_ovf, sub_ovf;
    logic [WIDTH-1:0]  sc_out;
    logic              sc_zero, sc_ovf;

    logic [WIDTH:0]    mul_sum;
    logic [W2-1:0]     mul_next;
    logic [WIDTH:0]    div_sh;
    logic [WIDTH:0]    div_trial;
    logic [W2-1:0]     div_next;
    logic              last_iter;

    logic [W2-1:0]     prod_fix;
    logic [WIDTH-1:0]  q_fix, r_fix;
    logic [WIDTH-1:0]  fix_hi, fix_lo;

    assign in_ready    = (state_q == S_IDLE);
    assign busy        = ~in_ready;
    assign out_valid   = out_valid_q;
    assign out         = out_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

    assign accept    = in_valid & in_ready;
    assign is_mul    = (control == F_MULT) || (control == F_MULTU);
    assign is_div    = (control == F_DIV) || (control == F_DIVU);
    assign is_mdu    = is_mul | is_div;
    assign is_signed = (control == F_MULT) || (control == F_DIV);

    assign a_neg = is_signed & read1[WIDTH-1];
    assign b_neg = is_signed & foutput[WIDTH-1];
    assign a_mag = a_neg ? -read1 : read1;
    assign b_mag = b_neg ? -foutput : foutput;

    assign sum_w   = read1 + foutput;
    assign diff_w  = read1 - foutput;
    assign add_ovf = (read1[WIDTH-1] == foutput[WIDTH-1]) &&
                     (sum_w[WIDTH-1] != read1[WIDTH-1]);
    assign sub_ovf = (read1[WIDTH-1] != foutput[WIDTH-1]) &&
                     (diff_w[WIDTH-1] != read1[WIDTH-1]);

    always_comb begin
        sc_out  = '0;
        sc_zero = 1'b0;
        sc_ovf  = 1'b0;
        unique case (control)
            F_AND0, F_AND1: sc_out = read1 & foutput;
            F_OR0, F_OR1:   sc_out = read1 | foutput;
            F_NOR:          sc_out = ~(read1 | foutput);
            F_ADD: begin
                sc_out = sum_w;
                sc_ovf = add_ovf;
            end
            F_ADDU:         sc_out = sum_w;
            F_SUB: begin
                sc_out = diff_w;
                sc_ovf = sub_ovf;
            end
            F_SLT0, F_SLT1:
                sc_out = {{(WIDTH-1){1'b0}},
                          $signed(read1) < $signed(foutput)};
            F_SLTU:
                sc_out = {{(WIDTH-1){1'b0}}, read1 < foutput};
            F_BEQ:          sc_zero = (read1 == foutput);
            F_BNE:          sc_zero = (read1 != foutput);
            F_MFLO:         sc_out = lo_q;
            F_MFHI:         sc_out = hi_q;
            default:        sc_out = '0;
        endcase
    end

    // Shift-add: the multiplier sits in the low half and is consumed LSB
    // first while partial sums enter from the top.
    assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} +
                      {1'b0, (acc_q[0] ? bmag_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: remainder in the high half, dividend shifted out of
    // the low half while quotient bits shift in. The trial MSB is the borrow.
    assign div_sh    = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    assign div_trial = div_sh - {1'b0, bmag_q};
    assign div_next  = div_trial[WIDTH]
                     ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign q_fix    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign r_fix    = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    assign fix_hi   = div_op_q ? r_fix : prod_fix[W2-1:WIDTH];
    assign fix_lo   = div_op_q ? q_fix : prod_fix[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        bmag_d      = bmag_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        div_op_d    = div_op_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_d       = out_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept && is_div && (foutput == '0)) begin
                    lo_d        = '1;
                    hi_d        = read1;
                    out_d       = '1;
                    zero_d      = 1'b0;
                    ovf_d       = 1'b0;
                    dbz_d       = 1'b1;
                    out_valid_d = 1'b1;
                end else if (accept && is_mdu) begin
                    // Iterate on magnitudes; signs are restored in FIX.
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    div_op_d = is_div;
                    cnt_d    = '0;
                    bmag_d   = is_div ? b_mag : a_mag;
                    acc_d    = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                    state_d  = is_div ? S_DIV : S_MUL;
                end else if (accept) begin
                    out_d       = sc_out;
                    zero_d      = sc_zero;
                    ovf_d       = sc_ovf;
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) state_d = S_FIX;
            end
            S_FIX: begin
                hi_d        = fix_hi;
                lo_d        = fix_lo;
                out_d       = fix_lo;
                zero_d      = 1'b0;
                ovf_d       = 1'b0;
                dbz_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            bmag_q      <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            div_op_q    <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_q       <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            bmag_q      <= bmag_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            div_op_q    <= div_op_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_q       <= out_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
